// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the fetch controller
package ifetch_pkg;
  localparam int INSTR_BYTES = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} ifetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: prefetch queue of {pc, instr} entries; flush beats push/pop, head reads 0 when empty
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    do_pop   = pop && !flush && !empty;
    do_push  = push && !flush && (!full || do_pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_pop);
    count_d  = flush ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: IF-stage fetch sequencer (start/redirect in, imem addr/data, valid/ready {pc,instr} out, busy); IFETCH_PERF_EN adds perf_fetch_cnt/perf_flush_cnt
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        busy
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  localparam logic [31:0] IMEM_END = 32'(IMEM_WORDS * INSTR_BYTES);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  ifetch_state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic in_range, push, pop, full, empty;
  logic [CW-1:0] count;
  fetch_entry_t head;
  always_comb begin
    in_range   = fetch_pc_q < IMEM_END;
    pop        = !empty && out_ready;
    push       = state_q == RUN && in_range && (!full || pop) && !redirect_valid;
    fetch_pc_d = redirect_valid ? redirect_pc & ~32'h3 : push ? fetch_pc_q + 32'(INSTR_BYTES) : fetch_pc_q;
    state_d    = redirect_valid ? ((state_q == IDLE && !start) ? IDLE : RUN)
               : (state_q == IDLE && start) ? RUN
               : (state_q == RUN && !in_range) ? DRAIN : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end
  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ('{pc: fetch_pc_q, instr: imem_rdata}),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  assign imem_addr = fetch_pc_q;
  assign out_valid = !empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign busy      = state_q != IDLE;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(push);
    flush_cnt_d = flush_cnt_q + (redirect_valid ? 32'(count) : 32'h0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed self-checking bench for ifetch_ctrl
module tb_ifetch_ctrl;
  logic clk = 0, rst_n = 0, start = 0, redirect_valid = 0, out_ready = 0;
  logic [31:0] redirect_pc = 0, imem_addr, imem_rdata, out_instr, out_pc;
  logic out_valid, busy;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  assign imem_rdata = 32'h1000_0000 + {26'b0, imem_addr[7:2]};
  ifetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .busy           (busy)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 0;
    #1;
    rst_n = 1;
  endtask
  task automatic do_start;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1;
    redirect_pc = pc;
    tick();
    redirect_valid = 0;
  endtask
  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", imem_addr, 0);
`ifdef IFETCH_PERF_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 0);
    chk("rst_perf_flush", perf_flush_cnt, 0);
`endif
    rst_n = 1;
    do_redirect(32'h81);
    chk("idle_redir_busy", busy, 0);
    chk("idle_redir_addr", imem_addr, 32'h80);
    tick();
    chk("idle_no_push", out_valid, 0);
    start = 1;
    do_redirect(32'h42);
    start = 0;
    chk("redir_start_busy", busy, 1);
    chk("redir_start_addr", imem_addr, 32'h40);
    do_reset();
    out_ready = 1;
    do_start();
    chk("start_lat_valid", out_valid, 0);
    chk("start_busy", busy, 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", out_valid, 1);
      chk("stream_pc", out_pc, 32'(4 * i));
      chk("stream_instr", out_instr, 32'h1000_0000 + 32'(i));
      tick();
    end
    do_reset();
    out_ready = 0;
    do_start();
    repeat (6) tick();
    chk("stall_addr", imem_addr, 32'h10);
    chk("stall_head", out_pc, 0);
    chk("stall_valid", out_valid, 1);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("resume_valid", out_valid, 1);
      chk("resume_pc", out_pc, 32'(4 * i));
      tick();
    end
    do_reset();
    out_ready = 0;
    do_start();
    repeat (3) tick();
    chk("q3_addr", imem_addr, 32'hC);
    do_redirect(32'h22);
    chk("flush_valid", out_valid, 0);
    chk("flush_addr", imem_addr, 32'h20);
`ifdef IFETCH_PERF_EN
    chk("perf_flush3", perf_flush_cnt, 3);
    chk("perf_fetch3", perf_fetch_cnt, 3);
`endif
    tick();
    chk("redir_valid", out_valid, 1);
    chk("redir_pc", out_pc, 32'h20);
    chk("redir_instr", out_instr, 32'h1000_0008);
    out_ready = 1;
    for (int p = 32'h20; p <= 32'hFC; p += 4) begin
      chk("tail_valid", out_valid, 1);
      chk("tail_pc", out_pc, 32'(p));
      chk("tail_instr", out_instr, 32'h1000_0000 + 32'(p / 4));
      tick();
    end
    chk("drain_valid", out_valid, 0);
    chk("drain_busy", busy, 1);
    chk("drain_addr", imem_addr, 32'h100);
    start = 1;
    tick();
    start = 0;
    chk("drain_hold_valid", out_valid, 0);
    chk("drain_hold_addr", imem_addr, 32'h100);
    do_redirect(32'h0);
    chk("drain_redir_valid", out_valid, 0);
    tick();
    chk("rerun_valid", out_valid, 1);
    chk("rerun_pc", out_pc, 0);
    chk("rerun_busy", busy, 1);
    do_redirect(32'h40);
    chk("pop_redir_valid", out_valid, 0);
    tick();
    chk("pop_redir_pc", out_pc, 32'h40);
    chk("pop_redir_instr", out_instr, 32'h1000_0010);
    #2;
    rst_n = 0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_pc", out_pc, 0);
    chk("async_instr", out_instr, 0);
    chk("async_busy", busy, 0);
    chk("async_addr", imem_addr, 0);
`ifdef IFETCH_PERF_EN
    chk("async_perf_fetch", perf_fetch_cnt, 0);
    chk("async_perf_flush", perf_flush_cnt, 0);
`endif
    rst_n = 1;
    tick();
    out_ready = 0;
    do_start();
    repeat (2) tick();
    chk("q2_addr", imem_addr, 32'h8);
    do_redirect(32'h0);
    chk("q2_flush_valid", out_valid, 0);
`ifdef IFETCH_PERF_EN
    chk("perf_flush2", perf_flush_cnt, 2);
    chk("perf_fetch2", perf_fetch_cnt, 2);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
